// File: rtl/median_frame_sequencer_pkg.sv
// Shared types and defaults for the median-filter frame sequencer.
package median_frame_sequencer_pkg;

    localparam int STATE_W      = 3;
    localparam int IMG_W_DEF    = 160;
    localparam int IMG_H_DEF    = 120;
    localparam int THRESH_W_DEF = 13;
    localparam int TIMER_W      = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        FILTER  = 3'd3,
        SETTLE  = 3'd4,
        EVAL    = 3'd5,
        WAKE    = 3'd6,
        SLEEP   = 3'd7
    } state_t;

endpackage

// File: rtl/median_frame_sequencer_cycle_timer.sv
// Load/run/expire down-counter; expire is high on the last cycle of a loaded interval.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (run && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = run && (cnt == W'(1));

endmodule

// File: rtl/median_frame_sequencer.sv
// Frame sequencer: capture -> median filter -> wake interrupt or timed sleep.
// Define FRAME_TIMEOUT_EN to add the FILTER watchdog and the sticky timeout_err flag.
module median_frame_sequencer
    import median_frame_sequencer_pkg::*;
#(
    parameter int IMG_W        = IMG_W_DEF,
    parameter int IMG_H        = IMG_H_DEF,
    parameter int SLEEP_CYCLES = 1000,
    parameter int THRESH_W     = THRESH_W_DEF,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cam_frame_start,
    input  logic                cam_pixel_valid,
    input  logic [THRESH_W-1:0] threshold_in,
    output logic [THRESH_W-1:0] threshold_out,
    output logic                mem_we,
    output logic [7:0]          mem_x,
    output logic [7:0]          mem_y,
    output logic                filter_start,
    input  logic                filter_done,
    input  logic                filter_wakeup,
    output logic                wake_irq,
    input  logic                wake_ack,
    output logic                busy,
    output logic [2:0]          state_out,
    output logic [15:0]         frame_count,
    output logic                timeout_err
);

    localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);

    state_t state, next_state;
    logic [7:0] x_q, y_q;
    logic last_px, tmr_load, tmr_run, tmr_expire;
    logic [TIMER_W-1:0] tmr_val;

    // A frame-start pulse forces its own pixel to (0,0) even mid-capture.
    assign mem_x   = cam_frame_start ? 8'd0 : x_q;
    assign mem_y   = cam_frame_start ? 8'd0 : y_q;
    assign mem_we  = cam_pixel_valid &&
                     ((state == ARM && cam_frame_start) || state == CAPTURE);
    assign last_px = mem_we && mem_x == X_LAST && mem_y == Y_LAST;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = ARM;
            ARM: begin
                if (!enable)              next_state = IDLE;
                else if (cam_frame_start) next_state = last_px ? FILTER : CAPTURE;
            end
            CAPTURE: begin
                if (!enable)      next_state = IDLE;
                else if (last_px) next_state = FILTER;
            end
            FILTER: begin
                if (!enable)          next_state = IDLE;
                else if (filter_done) next_state = SETTLE;
`ifdef FRAME_TIMEOUT_EN
                else if (tmr_expire)  next_state = IDLE;
`endif
            end
            SETTLE:  next_state = enable ? EVAL : IDLE;
            EVAL: begin
                if (!enable)            next_state = IDLE;
                else if (filter_wakeup) next_state = WAKE;
                else                    next_state = SLEEP;
            end
            WAKE:    if (wake_ack) next_state = IDLE;
            SLEEP: begin
                if (!enable)         next_state = IDLE;
                else if (tmr_expire) next_state = ARM;
            end
            default: next_state = IDLE;
        endcase
    end

    // SLEEP and FILTER are never adjacent, so one timer serves both.
    assign tmr_load = (next_state != state) && (next_state == SLEEP || next_state == FILTER);
    assign tmr_val  = (next_state == SLEEP) ? TIMER_W'(SLEEP_CYCLES) : TIMER_W'(TIMEOUT_CYC);
`ifdef FRAME_TIMEOUT_EN
    assign tmr_run  = (state == SLEEP) || (state == FILTER);
`else
    assign tmr_run  = (state == SLEEP);
`endif

    cycle_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            threshold_out <= '0;
            filter_start  <= 1'b0;
            wake_irq      <= 1'b0;
            busy          <= 1'b0;
            frame_count   <= '0;
        end else begin
            state        <= next_state;
            filter_start <= (next_state == FILTER) || (next_state == SETTLE) ||
                            (next_state == EVAL);
            wake_irq     <= (next_state == WAKE);
            busy         <= (next_state != IDLE);
            if (state == ARM && enable && cam_frame_start)
                threshold_out <= threshold_in;
            if (state == EVAL && enable)
                frame_count <= frame_count + 16'd1;
            if (next_state != CAPTURE) begin
                x_q <= '0;
                y_q <= '0;
            end else if (mem_we) begin
                x_q <= (mem_x == X_LAST) ? 8'd0 : mem_x + 8'd1;
                y_q <= (mem_x == X_LAST) ? mem_y + 8'd1 : mem_y;
            end else if (cam_frame_start) begin
                x_q <= '0;
                y_q <= '0;
            end
        end
    end

`ifdef FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timeout_err <= 1'b0;
        else if (state == FILTER && enable && !filter_done && tmr_expire)
            timeout_err <= 1'b1;
    end
`else
    assign timeout_err = 1'b0;
`endif

    assign state_out = state;

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Directed/randomized bench for median_frame_sequencer with a pixel-index address model.
module tb_median_frame_sequencer;

    localparam int W = 4, H = 2, SLP = 5, TMO = 20, TW = 13;

    logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic cam_frame_start = 1'b0, cam_pixel_valid = 1'b0;
    logic filter_done = 1'b0, filter_wakeup = 1'b0, wake_ack = 1'b0;
    logic [TW-1:0] threshold_in = '0, threshold_out;
    logic mem_we, filter_start, wake_irq, busy, timeout_err;
    logic [7:0] mem_x, mem_y;
    logic [2:0] state_out;
    logic [15:0] frame_count;

    int total = 0, passed = 0;
    int pix_idx = 0, exp_frames = 0;
    logic [15:0] got_wr[$], exp_wr[$];

    always #5 clk = ~clk;

    median_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .SLEEP_CYCLES(SLP), .THRESH_W(TW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cam_frame_start(cam_frame_start), .cam_pixel_valid(cam_pixel_valid),
        .threshold_in(threshold_in), .threshold_out(threshold_out),
        .mem_we(mem_we), .mem_x(mem_x), .mem_y(mem_y),
        .filter_start(filter_start), .filter_done(filter_done), .filter_wakeup(filter_wakeup),
        .wake_irq(wake_irq), .wake_ack(wake_ack), .busy(busy), .state_out(state_out),
        .frame_count(frame_count), .timeout_err(timeout_err)
    );

    // Record every memory write mid-cycle, away from the clock edge.
    always @(negedge clk) if (reset && mem_we) got_wr.push_back({mem_x, mem_y});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pixel after 0..2 idle cycles; the model addresses pixel k as (k%W, k/W).
    task automatic pixel(input bit fs);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        cam_frame_start = fs;
        cam_pixel_valid = 1'b1;
        if (fs) pix_idx = 0;
        exp_wr.push_back({8'(pix_idx % W), 8'(pix_idx / W)});
        pix_idx = pix_idx + 1;
        tick();
        cam_frame_start = 1'b0;
        cam_pixel_valid = 1'b0;
    endtask

    task automatic frame();
        for (int i = 0; i < W * H; i++) pixel(i == 0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), got_wr[i], exp_wr[i]);
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic count_in(input logic [2:0] s, input int lim, output int n);
        n = 0;
        while (state_out == s && n < lim) begin
            tick();
            n = n + 1;
        end
    endtask

    initial begin
        int n, d;
        logic [TW-1:0] thr;

        // Reset values
        #12;
        chk("rst_state", state_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_xy", {mem_x, mem_y}, 0);
        chk("rst_fstart", filter_start, 0);
        chk("rst_irq", wake_irq, 0);
        chk("rst_fcnt", frame_count, 0);
        chk("rst_thr", threshold_out, 0);
        chk("rst_tmo", timeout_err, 0);
        reset = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        chk("arm_state", state_out, 1);
        chk("arm_busy", busy, 1);

        // Frame with wake: threshold latched at frame start only
        threshold_in = 13'd100;
        pixel(1'b1);
        chk("a_cap_state", state_out, 2);
        threshold_in = 13'd200;
        for (int i = 1; i < W * H; i++) begin
            if (i == 4) chk("a_thr_mid", threshold_out, 100);
            pixel(1'b0);
        end
        chk("a_filter", state_out, 3);
        chk("a_fstart", filter_start, 1);
        chk("a_thr_end", threshold_out, 100);
        check_writes("a");
        d = $urandom_range(0, 10);
        repeat (d) tick();
        chk("a_wait_filter", state_out, 3);
        filter_done = 1'b1;
        filter_wakeup = 1'b1;
        tick();
        chk("a_settle", state_out, 4);
        filter_done = 1'b0;
        tick();
        chk("a_eval", state_out, 5);
        chk("a_eval_fstart", filter_start, 1);
        tick();
        exp_frames = exp_frames + 1;
        chk("a_wake", state_out, 6);
        chk("a_irq", wake_irq, 1);
        chk("a_fstart_drop", filter_start, 0);
        chk("a_fcnt", frame_count, exp_frames);
        filter_wakeup = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        chk("a_wake_hold", {state_out, wake_irq}, {3'd6, 1'b1});
        wake_ack = 1'b1;
        tick();
        wake_ack = 1'b0;
        chk("a_ack_idle", state_out, 0);
        chk("a_ack_irq", wake_irq, 0);
        chk("a_ack_busy", busy, 0);

        // Frame with sleep
        enable = 1'b1;
        tick();
        thr = TW'($urandom);
        threshold_in = thr;
        pixel(1'b1);
        threshold_in = ~thr;
        for (int i = 1; i < W * H; i++) pixel(1'b0);
        chk("b_filter", state_out, 3);
        chk("b_thr", threshold_out, thr);
        check_writes("b");
        filter_done = 1'b1;
        tick();
        filter_done = 1'b0;
        tick();
        tick();
        exp_frames = exp_frames + 1;
        chk("b_sleep", state_out, 7);
        count_in(3'd7, 50, n);
        chk("b_sleep_len", n, SLP);
        chk("b_rearm", state_out, 1);
        chk("b_fcnt", frame_count, exp_frames);

        // Restart mid-capture, then abort in FILTER
        threshold_in = TW'($urandom);
        for (int i = 0; i < 5; i++) pixel(i == 0);
        pixel(1'b1);
        for (int i = 1; i < W * H - 1; i++) pixel(1'b0);
        chk("c_still_cap", state_out, 2);
        pixel(1'b0);
        chk("c_filter", state_out, 3);
        check_writes("c");
        enable = 1'b0;
        tick();
        chk("c_abort", state_out, 0);
        chk("c_abort_fstart", filter_start, 0);
        chk("c_fcnt", frame_count, exp_frames);

        // FILTER with no done
        enable = 1'b1;
        tick();
        frame();
        check_writes("d");
        chk("d_filter", state_out, 3);
        count_in(3'd3, 60, n);
`ifdef FRAME_TIMEOUT_EN
        chk("d_tmo_len", n, TMO);
        chk("d_tmo_idle", state_out, 0);
        chk("d_tmo_err", timeout_err, 1);
`else
        chk("d_no_tmo", n, 60);
        chk("d_tmo_err", timeout_err, 0);
        enable = 1'b0;
        tick();
        chk("d_abort", state_out, 0);
`endif
        chk("d_fcnt", frame_count, exp_frames);

        // Asynchronous reset mid-capture
        enable = 1'b1;
        tick();
        if (state_out == 3'd0) tick();
        for (int i = 0; i < 3; i++) pixel(i == 0);
        chk("e_cap", state_out, 2);
        cam_pixel_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("e_rst_state", state_out, 0);
        chk("e_rst_we", mem_we, 0);
        chk("e_rst_xy", {mem_x, mem_y}, 0);
        chk("e_rst_outs", {busy, filter_start, wake_irq, timeout_err}, 0);
        chk("e_rst_fcnt", frame_count, 0);
        chk("e_rst_thr", threshold_out, 0);
        cam_pixel_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
